// File: rtl/reg_file_cmd_ctrl.sv
// Command sequencer: parses rx byte frames into register-file writes and reads and ALU launches, and returns results on tx.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module reg_file_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_WIDTH      = 16,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  input  logic [ALU_WIDTH-1:0]  alu_out,
  input  logic                  alu_valid,
  input  logic                  tx_busy,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  busy
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] OP_A     = 4'd5;
  localparam logic [3:0] OP_B     = 4'd6;
  localparam logic [3:0] ALU_FUN  = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_RD    = 4'd9;
  localparam logic [3:0] TX_LO    = 4'd10;
  localparam logic [3:0] TX_HI    = 4'd11;

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  logic [3:0]            state_q, state_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ALU_WIDTH-1:0]  alu_res_q, alu_res_d;
  logic                  tx_gap_q, tx_gap_d;
  logic                  tx_fire;

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // The high result byte gets one dead cycle after the low byte goes out.
  assign tx_fire = !tx_busy && ((state_q == TX_RD) || (state_q == TX_LO) ||
                                ((state_q == TX_HI) && !tx_gap_q));

  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_en_d     = alu_en_q;
    alu_fun_d    = alu_fun_q;
    rd_data_d    = rd_data_q;
    alu_res_d    = alu_res_q;
    tx_gap_d     = 1'b0;
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == CMD_WR)       state_d = WR_ADDR;
        else if (rx_data == CMD_RD)  state_d = RD_ADDR;
        else if (rx_data == CMD_OPS) state_d = OP_A;
        else if (rx_data == CMD_FUN) state_d = ALU_FUN;
      end
      WR_ADDR: if (rx_valid) begin
        rf_addr_d = rx_data[ADDR_WIDTH-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (rx_valid) begin
        rf_wr_data_d = rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = IDLE;
      end
      RD_ADDR: if (rx_valid) begin
        rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (rf_rd_valid) begin
        rd_data_d = rf_rd_data;
        state_d   = TX_RD;
      end
      OP_A: if (rx_valid) begin
        rf_addr_d    = '0;
        rf_wr_data_d = rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = OP_B;
      end
      OP_B: if (rx_valid) begin
        rf_addr_d    = ADDR_WIDTH'(1);
        rf_wr_data_d = rx_data;
        rf_wr_en_d   = 1'b1;
        state_d      = ALU_FUN;
      end
      ALU_FUN: if (rx_valid) begin
        alu_fun_d = rx_data[FUN_WIDTH-1:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (alu_valid) begin
        alu_res_d = alu_out;
        alu_en_d  = 1'b0;
        state_d   = TX_LO;
      end
      TX_RD: if (tx_fire) state_d = IDLE;
      TX_LO: if (tx_fire) begin
        state_d  = TX_HI;
        tx_gap_d = 1'b1;
      end
      TX_HI: if (tx_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef CMD_TIMEOUT_EN
    tmo_d = '0;
    if (!rx_valid && ((state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
                      (state_q == OP_A) || (state_q == OP_B) || (state_q == ALU_FUN))) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
      else                                     tmo_d   = tmo_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      rd_data_q    <= '0;
      alu_res_q    <= '0;
      tx_gap_q     <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      rd_data_q    <= rd_data_d;
      alu_res_q    <= alu_res_d;
      tx_gap_q     <= tx_gap_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  always_comb begin
    tx_data = '0;
    case (state_q)
      TX_RD:   tx_data = rd_data_q;
      TX_LO:   tx_data = alu_res_q[DATA_WIDTH-1:0];
      TX_HI:   tx_data = alu_res_q[ALU_WIDTH-1 -: DATA_WIDTH];
      default: tx_data = '0;
    endcase
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_rd_en   = rf_rd_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign alu_en     = alu_en_q;
  assign alu_fun    = alu_fun_q;
  assign tx_valid   = tx_fire;
  // A write frame ends in IDLE, so keep busy up through its strobe cycle.
  assign busy       = (state_q != IDLE) || rf_wr_en_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Bench for reg_file_cmd_ctrl: frame-level scoreboard of expected strobes, tx bytes and busy/alu_en windows.
module tb_reg_file_cmd_ctrl;
  localparam int T = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] rf_rd_data = '0;
  logic       rf_rd_valid = 1'b0;
  logic [15:0] alu_out = '0;
  logic       alu_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       rf_wr_en, rf_rd_en, alu_en, tx_valid, busy;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data, tx_data;

  reg_file_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16), .FUN_WIDTH(4),
                      .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_out(alu_out),
    .alu_valid(alu_valid), .tx_busy(tx_busy), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int c; logic [7:0] a; logic [7:0] d; } ev_t;
  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t tx_q[$];
  logic [7:0] mem [16];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int busy_from = -1, busy_to = -2;
  int alu_from = -1, alu_to = -2;
  logic [3:0] exp_fun = '0;
  bit hold_valid = 0;
  logic [7:0] hold_data = '0;
  localparam int NEVER = 1 << 30;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
    case (f)
      4'h1:    return {8'h00, a} + {8'h00, b};
      4'h2:    return {8'h00, a} - {8'h00, b};
      4'h3:    return a * b;
      default: return {a, b};
    endcase
  endfunction

  // Single compare process: every cycle, outputs against the scoreboard.
  always @(negedge clk) begin
    bit e;
    e = (wr_q.size() != 0) && (wr_q[0].c == cyc);
    chk("rf_wr_en", rf_wr_en, e);
    if (e) begin
      chk("rf_wr_addr", rf_addr, wr_q[0].a);
      chk("rf_wr_data", rf_wr_data, wr_q[0].d);
      void'(wr_q.pop_front());
    end
    e = (rd_q.size() != 0) && (rd_q[0].c == cyc);
    chk("rf_rd_en", rf_rd_en, e);
    if (e) begin
      chk("rf_rd_addr", rf_addr, rd_q[0].a);
      void'(rd_q.pop_front());
    end
    e = (tx_q.size() != 0) && (tx_q[0].c == cyc);
    chk("tx_valid", tx_valid, e);
    if (e) begin
      chk("tx_data", tx_data, tx_q[0].d);
      void'(tx_q.pop_front());
    end
    if (hold_valid) chk("tx_data_hold", tx_data, hold_data);
    e = (cyc >= alu_from) && (cyc <= alu_to);
    chk("alu_en", alu_en, e);
    if (e) chk("alu_fun", alu_fun, exp_fun);
    chk("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
    if (rst) begin
      chk("rst_rf_addr", rf_addr, 0);
      chk("rst_rf_wr_data", rf_wr_data, 0);
      chk("rst_alu_fun", alu_fun, 0);
      chk("rst_tx_data", tx_data, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rf_rd_valid = 1'b0;
    alu_valid = 1'b0;
    tx_busy = ($urandom_range(0, 2) == 0);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Bytes arriving while the DUT is waiting or transmitting must be dropped.
  task automatic noise();
    if ($urandom_range(0, 3) == 0) begin
      rx_valid = 1'b1;
      rx_data = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b, output int c);
    c = cyc;
    rx_valid = 1'b1;
    rx_data = b;
    tick();
  endtask

  task automatic tx_phase(input logic [7:0] d, input int hold, input bit last);
    int tries = 0;
    bit done = 0;
    int h = hold;
    hold_valid = 1;
    hold_data = d;
    while (!done) begin
      if (h > 0) begin
        tx_busy = 1'b1;
        h--;
      end else begin
        if (tries >= 20) tx_busy = 1'b0;
        tries++;
      end
      noise();
      if (!tx_busy) begin
        tx_q.push_back('{cyc, 8'h00, d});
        if (last) busy_to = cyc;
        done = 1;
      end
      tick();
    end
    hold_valid = 0;
  endtask

  task automatic wr_frame(input logic [7:0] ab, input logic [7:0] d);
    int c;
    gap();
    send(8'hAA, c);
    busy_from = c + 1;
    busy_to = NEVER;
    gap();
    send(ab, c);
    gap();
    wr_q.push_back('{cyc + 1, {4'h0, ab[3:0]}, d});
    busy_to = cyc + 1;
    mem[ab[3:0]] = d;
    send(d, c);
  endtask

  task automatic rd_frame(input logic [7:0] ab, input logic [7:0] rdata, input int hold);
    int c;
    gap();
    send(8'hBB, c);
    busy_from = c + 1;
    busy_to = NEVER;
    gap();
    send(ab, c);
    rd_q.push_back('{c + 1, {4'h0, ab[3:0]}, 8'h00});
    repeat ($urandom_range(1, 3)) begin
      noise();
      tick();
    end
    rf_rd_valid = 1'b1;
    rf_rd_data = rdata;
    noise();
    tick();
    tx_phase(rdata, hold, 1);
  endtask

  task automatic alu_frame(input bit ops, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] fb, input int hold);
    int c;
    logic [15:0] r;
    gap();
    send(ops ? 8'hCC : 8'hDD, c);
    busy_from = c + 1;
    busy_to = NEVER;
    if (ops) begin
      gap();
      wr_q.push_back('{cyc + 1, 8'h00, a});
      mem[0] = a;
      send(a, c);
      gap();
      wr_q.push_back('{cyc + 1, 8'h01, b});
      mem[1] = b;
      send(b, c);
    end
    gap();
    exp_fun = fb[3:0];
    send(fb, c);
    alu_from = c + 1;
    alu_to = NEVER;
    repeat ($urandom_range(1, 4)) begin
      noise();
      tick();
    end
    r = alu_model(mem[0], mem[1], fb[3:0]);
    alu_valid = 1'b1;
    alu_out = r;
    alu_to = cyc;
    noise();
    tick();
    tx_phase(r[7:0], hold, 0);
    noise();
    tick();
    tx_phase(r[15:8], 0, 1);
  endtask

  task automatic junk();
    logic [7:0] b;
    int c;
    do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD);
    send(b, c);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    wr_frame(8'h05, 8'h3C);
    chk("model_mem5", mem[5], 8'h3C);
    rd_frame(8'h15, 8'h81, 0);
    alu_frame(1, 8'h12, 8'h34, 8'h01, 0);
    chk("model_alu_add", alu_model(mem[0], mem[1], 4'h1), 16'h0046);
    alu_frame(0, 8'h00, 8'h00, 8'h03, 10);
    chk("model_alu_mul", alu_model(mem[0], mem[1], 4'h3), 16'h03A8);
    gap();
    send(8'h77, c);
    rd_frame(8'h02, mem[2], 0);

    // Reset in the middle of a write frame; the trailing data byte must be ignored.
    send(8'hAA, c);
    busy_from = c + 1;
    busy_to = NEVER;
    gap();
    send(8'h03, c);
    rst = 1'b1;
    busy_to = cyc - 1;
    tick();
    tick();
    rst = 1'b0;
    send(8'h3C, c);
    repeat (3) tick();

`ifdef CMD_TIMEOUT_EN
    send(8'hAA, c);
    busy_from = c + 1;
    busy_to = c + T;
    repeat (T + 3) tick();
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0] ab;
      ab = 8'($urandom);
      case ($urandom_range(0, 4))
        0: wr_frame(ab, 8'($urandom));
        1: rd_frame(ab, mem[ab[3:0]], $urandom_range(0, 3));
        2: alu_frame(1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
        3: alu_frame(0, 8'h00, 8'h00, 8'($urandom), 0);
        default: junk();
      endcase
    end

    repeat (5) tick();
    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("tx_q_drained", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_cmd_ctrl.md
# reg_file_cmd_ctrl

Command sequencer between the byte-stream receive path and the register file / ALU datapath. Parses command frames arriving one byte at a time, drives the register file's write/read strobes, address and write data, launches ALU operations on operands held at register addresses 0 and 1, and returns read data or ALU results to the transmit path with a valid/busy handshake. It is the only master of the register file port and the ALU enable.

## Interface

- DATA_WIDTH, 8, width of received/transmitted bytes and register file data
- ADDR_WIDTH, 4, register file address width
- ALU_WIDTH, 16, ALU result width (2*DATA_WIDTH)
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 1024, inter-byte timeout (used only with CMD_TIMEOUT_EN)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  DATA_WIDTH  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rf_rd_data  in  DATA_WIDTH  register file read data
- rf_rd_valid  in  1  one-cycle pulse, rf_rd_data valid
- alu_out  in  ALU_WIDTH  ALU result
- alu_valid  in  1  ALU result valid
- tx_busy  in  1  transmitter cannot accept a byte
- rf_wr_en  out  1  register file write strobe
- rf_rd_en  out  1  register file read strobe
- rf_addr  out  ADDR_WIDTH  register file address
- rf_wr_data  out  DATA_WIDTH  register file write data
- alu_en  out  1  ALU enable
- alu_fun  out  FUN_WIDTH  ALU function
- tx_data  out  DATA_WIDTH  byte to transmit
- tx_valid  out  1  one-cycle pulse, tx_data valid
- busy  out  1  high whenever state is not IDLE

## Operation

- Commands (first byte): 0xAA write (addr, data); 0xBB read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU no operands (fun). Any other first byte is ignored; state stays IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- Address byte: low ADDR_WIDTH bits latched into rf_addr; upper bits discarded. Function byte: low FUN_WIDTH bits latched into alu_fun.
- 0xAA: IDLE→WR_ADDR→WR_DATA; on data byte, rf_wr_en high for exactly one cycle with rf_wr_data = byte; return to IDLE. No response byte.
- 0xBB: IDLE→RD_ADDR; on address byte, rf_rd_en pulses one cycle, go RD_WAIT; on rf_rd_valid latch rf_rd_data, go TX_RD; send one byte, return IDLE.
- 0xCC: OP_A byte written to address 0, OP_B byte written to address 1 (one-cycle rf_wr_en each), then ALU_FUN.
- 0xDD: IDLE→ALU_FUN directly.
- ALU_FUN: on function byte, alu_en high from next cycle until alu_valid; latch alu_out; go TX_LO (sends bits [7:0]), then TX_HI (bits [15:8]), then IDLE.
- TX states: tx_valid pulses one cycle only in a cycle where tx_busy is low; byte held stable until sent; advance one cycle after pulse.
- rx_valid in RD_WAIT, ALU_WAIT, TX_* is dropped (no buffering).
- rf_wr_en and rf_rd_en never high simultaneously.

## Timing

- Reset values: all outputs 0; rf_addr 0; state IDLE. Reset asserted mid-frame aborts with no further strobes; latched bytes discarded.
- rx_valid at cycle N → state/latch update at edge N+1; write/read strobe visible cycle N+1, for one cycle.
- rf_rd_valid at cycle M → tx_valid earliest M+1 (if tx_busy low).
- alu_valid at cycle K → alu_en low at K+1, first tx_valid earliest K+1; second tx_valid earliest 2 cycles after the first.
- busy rises the cycle after the command byte, falls the cycle after the last strobe/tx pulse.

## Configuration

- CMD_TIMEOUT_EN defined: counter of TIMEOUT_CYCLES clears on every accepted rx_valid; expiry in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B or ALU_FUN returns to IDLE with no strobe issued (an already-written operand A stays written). Wait/TX states never time out.
- Not defined: no counter; partial frames wait indefinitely.

## Test plan

- Reset, then 0xAA,0x05,0x3C → single rf_wr_en pulse, rf_addr=5, rf_wr_data=0x3C; no tx_valid; busy low after.
- 0xBB,0x15 with rf_rd_data=0x81 returned → rf_rd_en pulse with rf_addr=5; one tx_valid with tx_data=0x81.
- 0xCC,0x12,0x34,0x01, alu_out=0x0046 → writes 0x12@0, 0x34@1; alu_en until alu_valid; tx 0x46 then 0x00.
- tx_busy held high 10 cycles during TX_LO → tx_valid withheld, tx_data stable, pulses once after busy drops.
- 0x77 then 0xBB, 0x02 → 0x77 ignored, read of address 2 proceeds normally.
- Reset asserted after 0xAA,0x03 → no rf_wr_en, all outputs 0; with CMD_TIMEOUT_EN, 0xAA then silence for TIMEOUT_CYCLES → busy falls, no write.
